dsp_chain_operand_feeder: RTL and testbench

DSP_CHAIN_OPERAND_FEEDER -- requirements
Module: dsp_chain_operand_feeder

---
 rtl/dsp_chain_pkg.sv | 43 ++++
 rtl/dsp_feeder_res_fifo.sv | 56 +++++
 rtl/dsp_chain_operand_feeder.sv | 179 +++++++++++++++++
 tb/tb_dsp_chain_operand_feeder.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_chain_pkg.sv
// Shared widths, operand-slice offsets and state encoding for the DSP chain operand feeder.
// The 192-bit beat holds three 64-bit stage groups; each group is {bot_b, bot_a, top_b, top_a}.
package dsp_chain_pkg;

   localparam int FP16_W        = 16;
   localparam int FP32_W        = 32;
   localparam int STAGES        = 3;
   localparam int OPS_PER_STAGE = 4;
   localparam int STAGE_OPS_W   = OPS_PER_STAGE * FP16_W;
   localparam int IN_W          = STAGES * STAGE_OPS_W;

   localparam int STAGE1_OFF = 0;
   localparam int STAGE2_OFF = STAGE_OPS_W;
   localparam int STAGE3_OFF = 2 * STAGE_OPS_W;

   localparam int TOP_A_OFF = 0;
   localparam int TOP_B_OFF = FP16_W;
   localparam int BOT_A_OFF = 2 * FP16_W;
   localparam int BOT_B_OFF = 3 * FP16_W;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } feeder_state_e;

   typedef struct packed {
      logic [FP16_W-1:0] bot_b;
      logic [FP16_W-1:0] bot_a;
      logic [FP16_W-1:0] top_b;
      logic [FP16_W-1:0] top_a;
   } stage_ops_t;

   function automatic stage_ops_t stage_slice(input logic [IN_W-1:0] d, input int base);
      stage_ops_t s;
      s.top_a = d[base + TOP_A_OFF +: FP16_W];
      s.top_b = d[base + TOP_B_OFF +: FP16_W];
      s.bot_a = d[base + BOT_A_OFF +: FP16_W];
      s.bot_b = d[base + BOT_B_OFF +: FP16_W];
      return s;
   endfunction

endpackage

// File: rtl/dsp_feeder_res_fifo.sv
// Result FIFO for the operand feeder: registered read/write pointers and an occupancy count.
// Pointers wrap naturally because DEPTH is a power of two.
module dsp_feeder_res_fifo #(
   parameter  int W     = 33,
   parameter  int DEPTH = 8,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic [W-1:0]  push_data,
   input  logic          pop,
   output logic [W-1:0]  head_data,
   output logic          empty,
   output logic [CW-1:0] count
);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [CW-1:0] count_q;
   logic          full;
   logic          pop_ok;
   logic          push_ok;

   assign empty   = (count_q == '0);
   assign full    = (count_q == CW'(DEPTH));
   assign pop_ok  = pop && !empty;
   // A push into a full FIFO is still legal when the head leaves in the same cycle.
   assign push_ok = push && (!full || pop_ok);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({push_ok, pop_ok})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr_q] <= push_data;
   end

   assign head_data = mem[rd_ptr_q];
   assign count     = count_q;

endmodule

// File: rtl/dsp_chain_operand_feeder.sv
// Feeds a three-stage fp16 sum-of-products chain with skewed operands and collects the
// fp32 chain results into a FIFO-backed stream, framing the work with in_last/frame_done.
module dsp_chain_operand_feeder
   import dsp_chain_pkg::*;
#(
   parameter int STAGE_LAT  = 1,
   parameter int RES_LAT    = 5,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [IN_W-1:0]     in_data,
   input  logic                in_last,
   output logic [FP16_W-1:0]   top_a1,
   output logic [FP16_W-1:0]   top_b1,
   output logic [FP16_W-1:0]   bot_a1,
   output logic [FP16_W-1:0]   bot_b1,
   output logic [FP16_W-1:0]   top_a2,
   output logic [FP16_W-1:0]   top_b2,
   output logic [FP16_W-1:0]   bot_a2,
   output logic [FP16_W-1:0]   bot_b2,
   output logic [FP16_W-1:0]   top_a3,
   output logic [FP16_W-1:0]   top_b3,
   output logic [FP16_W-1:0]   bot_a3,
   output logic [FP16_W-1:0]   bot_b3,
   input  logic [FP32_W-1:0]   chain_result,
   output logic [FP32_W-1:0]   res_data,
   output logic                res_valid,
   input  logic                res_ready,
   output logic                res_last,
   output logic                frame_done,
   output logic [15:0]         beat_count,
   output feeder_state_e       dbg_state,
   output logic [15:0]         dbg_occupancy
);

   localparam int S2_D    = STAGE_LAT + 1;
   localparam int S3_D    = 2 * STAGE_LAT + 1;
   localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
   localparam int ENTRY_W = FP32_W + 1;

   feeder_state_e      state_q;
   feeder_state_e      state_d;
   logic               accept;
   logic               emerge;
   logic               emerge_last;
   logic               drained;
   logic [RES_LAT:0]   vld_q;
   logic [RES_LAT:0]   last_q;
   logic [15:0]        inflight_q;
   logic [15:0]        occupancy;
   logic [15:0]        beat_q;
   stage_ops_t         s1_q;
   stage_ops_t         s2_q [S2_D];
   stage_ops_t         s3_q [S3_D];
   stage_ops_t         s2_out;
   stage_ops_t         s3_out;
   logic [ENTRY_W-1:0] fifo_head;
   logic               fifo_empty;
   logic [CNT_W-1:0]   fifo_count;

   // Both streams use valid/ready: a transfer happens on a rising clk edge where valid and
   // ready are both high; valid never waits on ready, and ready here is purely combinational
   // from state and occupancy, so no combinational path runs from in_valid to in_ready.
   assign accept = in_valid && in_ready;

   // Credits cover every beat that will eventually land in the FIFO, so the chain never stalls.
   assign occupancy = inflight_q + 16'(fifo_count);
   assign in_ready  = (state_q == ST_RUN) && (occupancy < 16'(FIFO_DEPTH));

   assign emerge      = vld_q[RES_LAT];
   assign emerge_last = last_q[RES_LAT];
   assign drained     = (inflight_q == '0) && fifo_empty;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      frame_done = 1'b0;
      case (state_q)
         ST_IDLE: state_d = ST_RUN;
         ST_RUN: begin
            if (accept && in_last) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (drained) begin
               state_d    = ST_RUN;
               frame_done = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Operand skew: stage k operands leave (k-1)*STAGE_LAT cycles after stage 1; idle slots carry zero.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_q <= '0;
         for (int i = 0; i < S2_D; i++) s2_q[i] <= '0;
         for (int i = 0; i < S3_D; i++) s3_q[i] <= '0;
      end else begin
         s1_q    <= accept ? stage_slice(in_data, STAGE1_OFF) : '0;
         s2_q[0] <= accept ? stage_slice(in_data, STAGE2_OFF) : '0;
         s3_q[0] <= accept ? stage_slice(in_data, STAGE3_OFF) : '0;
         for (int i = 1; i < S2_D; i++) s2_q[i] <= s2_q[i-1];
         for (int i = 1; i < S3_D; i++) s3_q[i] <= s3_q[i-1];
      end
   end

   assign s2_out = s2_q[S2_D-1];
   assign s3_out = s3_q[S3_D-1];

   assign top_a1 = s1_q.top_a;
   assign top_b1 = s1_q.top_b;
   assign bot_a1 = s1_q.bot_a;
   assign bot_b1 = s1_q.bot_b;
   assign top_a2 = s2_out.top_a;
   assign top_b2 = s2_out.top_b;
   assign bot_a2 = s2_out.bot_a;
   assign bot_b2 = s2_out.bot_b;
   assign top_a3 = s3_out.top_a;
   assign top_b3 = s3_out.top_b;
   assign bot_a3 = s3_out.bot_a;
   assign bot_b3 = s3_out.bot_b;

   // Tracking pipe: entry 0 lines up with stage-1 presentation, entry RES_LAT with chain_result.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vld_q      <= '0;
         last_q     <= '0;
         inflight_q <= '0;
      end else begin
         vld_q  <= {vld_q[RES_LAT-1:0], accept};
         last_q <= {last_q[RES_LAT-1:0], accept && in_last};
         case ({accept, emerge})
            2'b10:   inflight_q <= inflight_q + 16'd1;
            2'b01:   inflight_q <= inflight_q - 16'd1;
            default: inflight_q <= inflight_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         beat_q <= '0;
      end else if (frame_done) begin
         beat_q <= '0;
      end else if (accept && (beat_q != 16'hFFFF)) begin
         beat_q <= beat_q + 16'd1;
      end
   end

   dsp_feeder_res_fifo #(
      .W     (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_res_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (emerge),
      .push_data ({emerge_last, chain_result}),
      .pop       (res_ready),
      .head_data (fifo_head),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign res_valid     = !fifo_empty;
   assign res_data      = res_valid ? fifo_head[FP32_W-1:0] : '0;
   assign res_last      = res_valid && fifo_head[FP32_W];
   assign beat_count    = beat_q;
   assign dbg_state     = state_q;
   assign dbg_occupancy = occupancy;

endmodule

// File: tb/tb_dsp_chain_operand_feeder.sv
// Directed bench for dsp_chain_operand_feeder with a behavioural chain model and result scoreboard.
module tb_dsp_chain_operand_feeder;
   import dsp_chain_pkg::*;

   localparam int STAGE_LAT  = 1;
   localparam int RES_LAT    = 5;
   localparam int FIFO_DEPTH = 8;

   logic               clk       = 1'b0;
   logic               reset     = 1'b0;
   logic               in_valid  = 1'b0;
   logic               in_last   = 1'b0;
   logic               res_ready = 1'b0;
   logic [IN_W-1:0]    in_data   = '0;
   logic               in_ready;
   logic [FP16_W-1:0]  top_a1, top_b1, bot_a1, bot_b1;
   logic [FP16_W-1:0]  top_a2, top_b2, bot_a2, bot_b2;
   logic [FP16_W-1:0]  top_a3, top_b3, bot_a3, bot_b3;
   logic [FP32_W-1:0]  chain_result;
   logic [FP32_W-1:0]  res_data;
   logic               res_valid;
   logic               res_last;
   logic               frame_done;
   logic [15:0]        beat_count;
   feeder_state_e      dbg_state;
   logic [15:0]        dbg_occupancy;

   logic [RES_LAT-1:0][FP16_W-1:0] hist = '0;
   int          tests    = 0;
   int          fails    = 0;
   int          done_cnt = 0;
   int          max_occ  = 0;
   logic [15:0] bc_at_done = '0;
   logic [32:0] exp_q[$];
   logic [32:0] obs_q[$];

   dsp_chain_operand_feeder #(
      .STAGE_LAT  (STAGE_LAT),
      .RES_LAT    (RES_LAT),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_data       (in_data),
      .in_last       (in_last),
      .top_a1        (top_a1),
      .top_b1        (top_b1),
      .bot_a1        (bot_a1),
      .bot_b1        (bot_b1),
      .top_a2        (top_a2),
      .top_b2        (top_b2),
      .bot_a2        (bot_a2),
      .bot_b2        (bot_b2),
      .top_a3        (top_a3),
      .top_b3        (top_b3),
      .bot_a3        (bot_a3),
      .bot_b3        (bot_b3),
      .chain_result  (chain_result),
      .res_data      (res_data),
      .res_valid     (res_valid),
      .res_ready     (res_ready),
      .res_last      (res_last),
      .frame_done    (frame_done),
      .beat_count    (beat_count),
      .dbg_state     (dbg_state),
      .dbg_occupancy (dbg_occupancy)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
      $fatal(1);
   end

   // Chain model: result reflects the stage-1 top_a operand seen RES_LAT cycles earlier.
   function automatic logic [31:0] chain_fn(input logic [15:0] op);
      if (op == 16'h3C00) return 32'h40C0_0000;
      return {16'hBEEF, op};
   endfunction

   always @(posedge clk) hist <= {hist[RES_LAT-2:0], top_a1};
   assign chain_result = chain_fn(hist[RES_LAT-1]);

   // Monitor: records handshakes, frame_done pulses and peak credit occupancy.
   always @(negedge clk) begin
      if (reset) begin
         if (res_valid && res_ready) obs_q.push_back({res_last, res_data});
         if (frame_done) begin
            done_cnt   <= done_cnt + 1;
            bc_at_done <= beat_count;
         end
         if (int'(dbg_occupancy) > max_occ) max_occ <= int'(dbg_occupancy);
      end
   end

   // ---------------- helpers ----------------
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      tests++;
      assert (obs === exp_v) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [IN_W-1:0] mk_beat(input logic [15:0] base);
      logic [IN_W-1:0] d;
      d = '0;
      for (int k = 0; k < 12; k++) d[k*16 +: 16] = base + 16'(k);
      return d;
   endfunction

   task automatic send_beat(input logic [IN_W-1:0] d, input logic last, input int budget,
                            output int stalls);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      while (!in_ready && n < budget) begin
         tick();
         n++;
      end
      stalls = n;
      if (in_ready) begin
         exp_q.push_back({last, chain_fn(d[15:0])});
         tick();
      end else begin
         chk("send_timeout_in_ready", in_ready, 1);
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic cmp_queues(input string tag);
      logic [32:0] e;
      logic [32:0] o;
      chk({tag, "_result_count"}, obs_q.size(), exp_q.size());
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (obs_q.size() > 0) o = obs_q.pop_front();
         else                  o = '0;
         chk({tag, "_result"}, o, e);
      end
      obs_q.delete();
   endtask

   task automatic finish_frame(input string tag, input int budget);
      int start;
      int n;
      start = done_cnt;
      n = 0;
      while (done_cnt == start && n < budget) begin
         tick();
         n++;
      end
      chk({tag, "_frame_done"}, done_cnt - start, 1);
      repeat (3) tick();
      chk({tag, "_single_pulse"}, done_cnt - start, 1);
      cmp_queues(tag);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int st;
      int tot;
      int hi_cnt;
      int start;
      logic [IN_W-1:0] d;

      // reset state
      #3;
      chk("rst_in_ready",   in_ready, 0);
      chk("rst_res_valid",  res_valid, 0);
      chk("rst_res_last",   res_last, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_beat_count", beat_count, 0);
      chk("rst_top_a1",     top_a1, 0);
      chk("rst_bot_b3",     bot_b3, 0);
      chk("rst_state",      dbg_state, ST_IDLE);
      chk("rst_occupancy",  dbg_occupancy, 0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      tick();
      chk("post_rst_state", dbg_state, ST_RUN);
      chk("post_rst_ready", in_ready, 1);

      // t1: single beat of 1.0 operands, exact result latency
      res_ready = 1'b1;
      d = {12{16'h3C00}};
      send_beat(d, 1'b1, 0, st);
      chk("t1_top_a1",      top_a1, 16'h3C00);
      chk("t1_bot_b1",      bot_b1, 16'h3C00);
      chk("t1_state_drain", dbg_state, ST_DRAIN);
      chk("t1_ready_low",   in_ready, 0);
      chk("t1_beat_count",  beat_count, 1);
      repeat (5) tick();
      chk("t1_res_early",   res_valid, 0);
      tick();
      chk("t1_res_valid",   res_valid, 1);
      chk("t1_res_data",    res_data, 32'h40C0_0000);
      chk("t1_res_last",    res_last, 1);
      chk("t1_done_early",  frame_done, 0);
      tick();
      chk("t1_frame_done",  frame_done, 1);
      chk("t1_res_popped",  res_valid, 0);
      tick();
      chk("t1_done_once",   frame_done, 0);
      chk("t1_bc_clear",    beat_count, 0);
      chk("t1_state_run",   dbg_state, ST_RUN);
      cmp_queues("t1");

      // t2: operand skew across stages
      d = '0;
      for (int i = 0; i < 4; i++) begin
         d[i*16 +: 16]       = 16'h1111 + 16'(i);
         d[64 + i*16 +: 16]  = 16'h2221 + 16'(i);
         d[128 + i*16 +: 16] = 16'h3331 + 16'(i);
      end
      send_beat(d, 1'b1, 0, st);
      chk("t2_c1_top_a1", top_a1, 16'h1111);
      chk("t2_c1_bot_b1", bot_b1, 16'h1114);
      chk("t2_c1_top_a2", top_a2, 16'h0000);
      chk("t2_c1_top_a3", top_a3, 16'h0000);
      tick();
      chk("t2_c2_top_a1", top_a1, 16'h0000);
      chk("t2_c2_top_a2", top_a2, 16'h2221);
      chk("t2_c2_bot_b2", bot_b2, 16'h2224);
      chk("t2_c2_top_a3", top_a3, 16'h0000);
      tick();
      chk("t2_c3_top_a2", top_a2, 16'h0000);
      chk("t2_c3_top_a3", top_a3, 16'h3331);
      chk("t2_c3_bot_b3", bot_b3, 16'h3334);
      tick();
      chk("t2_c4_top_a3", top_a3, 16'h0000);
      chk("t2_c4_bot_b3", bot_b3, 16'h0000);
      finish_frame("t2", 30);

      // t3: 20-beat streaming frame
      tot = 0;
      for (int i = 0; i < 20; i++) begin
         send_beat(mk_beat(16'h0100 + 16'(i)), (i == 19), 4, st);
         tot += st;
      end
      chk("t3_no_stall",   tot, 0);
      chk("t3_beat_count", beat_count, 20);
      finish_frame("t3", 40);
      chk("t3_bc_at_done", bc_at_done, 20);
      chk("t3_bc_clear",   beat_count, 0);

      // t4: back-pressure from res_ready
      res_ready = 1'b0;
      for (int i = 0; i < 8; i++) send_beat(mk_beat(16'h0200 + 16'(i)), 1'b0, 0, st);
      chk("t4_ready_after_8", in_ready, 0);
      in_valid = 1'b1;
      in_data  = mk_beat(16'h0208);
      in_last  = 1'b0;
      hi_cnt = 0;
      repeat (10) begin
         if (in_ready) hi_cnt++;
         tick();
      end
      chk("t4_ready_held_low", hi_cnt, 0);
      chk("t4_occupancy",      dbg_occupancy, 8);
      chk("t4_head_valid",     res_valid, 1);
      chk("t4_head_data",      res_data, chain_fn(16'h0200));
      res_ready = 1'b1;
      for (int i = 8; i < 12; i++) send_beat(mk_beat(16'h0200 + 16'(i)), (i == 11), 20, st);
      finish_frame("t4", 60);
      chk("t4_bc_at_done", bc_at_done, 12);
      chk("t4_max_occ",    max_occ, 8);

      // t5: early last, offer during DRAIN
      for (int i = 0; i < 3; i++) send_beat(mk_beat(16'h0300 + 16'(i)), (i == 2), 4, st);
      start = done_cnt;
      in_valid = 1'b1;
      in_data  = mk_beat(16'h0400);
      in_last  = 1'b1;
      chk("t5_drain_ready", in_ready, 0);
      chk("t5_drain_state", dbg_state, ST_DRAIN);
      hi_cnt = 0;
      while (!in_ready && hi_cnt < 40) begin
         tick();
         hi_cnt++;
      end
      chk("t5_done_before_accept", done_cnt - start, 1);
      chk("t5_bc_at_done",         bc_at_done, 3);
      send_beat(mk_beat(16'h0400), 1'b1, 0, st);
      finish_frame("t5", 30);

      // t6: reset with four beats in flight
      for (int i = 0; i < 4; i++) send_beat(mk_beat(16'h0500 + 16'(i)), 1'b0, 4, st);
      start = done_cnt;
      reset = 1'b0;
      #1;
      chk("t6_top_a1",      top_a1, 0);
      chk("t6_top_a2",      top_a2, 0);
      chk("t6_top_a3",      top_a3, 0);
      chk("t6_bot_b3",      bot_b3, 0);
      chk("t6_in_ready",    in_ready, 0);
      chk("t6_res_valid",   res_valid, 0);
      chk("t6_res_last",    res_last, 0);
      chk("t6_frame_done",  frame_done, 0);
      chk("t6_beat_count",  beat_count, 0);
      chk("t6_state",       dbg_state, ST_IDLE);
      chk("t6_occupancy",   dbg_occupancy, 0);
      exp_q.delete();
      tick();
      tick();
      reset = 1'b1;
      repeat (15) tick();
      chk("t6_no_results",   obs_q.size(), 0);
      chk("t6_no_done",      done_cnt - start, 0);
      chk("t6_state_run",    dbg_state, ST_RUN);
      chk("t6_ready_back",   in_ready, 1);
      chk("t6_bc_zero",      beat_count, 0);

      // t7: clean frame after reset
      send_beat(mk_beat(16'h0600), 1'b1, 4, st);
      finish_frame("t7", 30);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
